// File: rtl/lane_parallel_classifier_if.sv
// Bundle of control, feature-stream, weight-ROM and result signals for lane_parallel_classifier.
// The classifier core connects through the slave modport and its environment through master.
interface lane_parallel_classifier_if #(
    parameter int NUM_CLASSES = 4,
    parameter int NUM_CELLS   = 1024,
    parameter int LANES       = 4,
    parameter int VALUE_BITS  = 8,
    parameter int WEIGHT_BITS = 8,
    parameter int ACC_BITS    = 24
);
    localparam int CLASS_BITS = $clog2(NUM_CLASSES);
    localparam int ADDR_BITS  = $clog2(NUM_CELLS / LANES);

    logic                                     start;
    logic                                     abort;
    logic                                     busy;
    logic [NUM_CLASSES*ACC_BITS-1:0]          bias_flat;
    // valid/ready: a beat (or result) transfers on a rising clk edge where both valid and
    // ready are high; the producer holds valid and its data stable until that edge.
    logic                                     feat_valid;
    logic                                     feat_ready;
    logic [LANES*VALUE_BITS-1:0]              feat_data;
    logic                                     w_en;
    logic [ADDR_BITS-1:0]                     w_addr;
    logic [NUM_CLASSES*LANES*WEIGHT_BITS-1:0] w_data_flat;
    logic                                     result_valid;
    logic                                     result_ready;
    logic [CLASS_BITS-1:0]                    best_class;
    logic [ACC_BITS-1:0]                      margin;
    logic                                     overflow;
    logic [NUM_CLASSES*ACC_BITS-1:0]          scores_flat;
    logic [2:0]                               fsm_state;

    modport slave (
        input  start, abort, bias_flat, feat_valid, feat_data, w_data_flat, result_ready,
        output busy, feat_ready, w_en, w_addr, result_valid, best_class, margin, overflow,
               scores_flat, fsm_state
    );

    modport master (
        output start, abort, bias_flat, feat_valid, feat_data, w_data_flat, result_ready,
        input  busy, feat_ready, w_en, w_addr, result_valid, best_class, margin, overflow,
               scores_flat, fsm_state
    );
endinterface

// File: rtl/lane_parallel_classifier.sv
// Lane-parallel linear classifier: saturating per-class accumulation of feature*weight beats,
// followed by a sequential argmax producing the best class and its margin over the runner-up.
module lane_parallel_classifier #(
    parameter int NUM_CLASSES = 4,
    parameter int NUM_CELLS   = 1024,
    parameter int LANES       = 4,
    parameter int VALUE_BITS  = 8,
    parameter int WEIGHT_BITS = 8,
    parameter int ACC_BITS    = 24
) (
    input logic                      clk,
    input logic                      rst_n,
    lane_parallel_classifier_if.slave bus
);
    localparam int CLASS_BITS = $clog2(NUM_CLASSES);
    localparam int BEATS      = NUM_CELLS / LANES;
    localparam int ADDR_BITS  = $clog2(BEATS);
    localparam int PROD_BITS  = VALUE_BITS + WEIGHT_BITS + 1;
    localparam int SUM_BITS   = PROD_BITS + $clog2(LANES) + 1;
    localparam int WIDE       = ((SUM_BITS > ACC_BITS) ? SUM_BITS : ACC_BITS) + 1;
    localparam logic signed [WIDE-1:0] ACC_MAX = {{(WIDE-ACC_BITS+1){1'b0}}, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [WIDE-1:0] ACC_MIN = {{(WIDE-ACC_BITS+1){1'b1}}, {(ACC_BITS-1){1'b0}}};
    localparam logic signed [ACC_BITS-1:0] SCORE_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

    typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, DRAIN = 3'd2, ARGMAX = 3'd3, DONE = 3'd4} state_t;
    state_t state, state_next;

    logic [ADDR_BITS-1:0]            beat_cnt;
    logic [CLASS_BITS-1:0]           cls_idx;
    logic                            pipe_valid;
    logic                            ovf_run;
    logic                            handshake;
    logic [LANES*VALUE_BITS-1:0]     feat_q;
    logic signed [ACC_BITS-1:0]      acc      [NUM_CLASSES];
    logic signed [ACC_BITS-1:0]      acc_next [NUM_CLASSES];
    logic [NUM_CLASSES-1:0]          clamp_hit;
    logic signed [PROD_BITS-1:0]     prod;
    logic signed [WIDE-1:0]          lane_sum;
    logic signed [WIDE-1:0]          acc_wide;
    logic signed [ACC_BITS-1:0]      cand, best_q, second_q, best_n, second_n;
    logic [CLASS_BITS-1:0]           best_idx_q, best_idx_n;
    logic [ACC_BITS:0]               diff;
    logic [NUM_CLASSES*ACC_BITS-1:0] scores_pack;

    assign handshake = bus.feat_valid && (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (handshake && beat_cnt == ADDR_BITS'(BEATS - 1)) state_next = DRAIN;
            DRAIN:   state_next = ARGMAX;
            ARGMAX:  if (cls_idx == CLASS_BITS'(NUM_CLASSES - 1)) state_next = DONE;
            DONE:    if (bus.result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.abort) state_next = IDLE;
    end

    always_comb begin
        bus.busy         = (state != IDLE);
        bus.feat_ready   = (state == RUN);
        bus.result_valid = (state == DONE);
        bus.w_en         = handshake;
        bus.w_addr       = beat_cnt;
        bus.fsm_state    = state;
    end

    // Lane products are summed wide enough that neither the sum nor acc+sum can wrap before the clamp.
    always_comb begin
        prod      = '0;
        lane_sum  = '0;
        acc_wide  = '0;
        clamp_hit = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            lane_sum = '0;
            for (int l = 0; l < LANES; l++) begin
                prod = PROD_BITS'($signed({1'b0, feat_q[l*VALUE_BITS +: VALUE_BITS]}))
                     * PROD_BITS'($signed(bus.w_data_flat[(k*LANES+l)*WEIGHT_BITS +: WEIGHT_BITS]));
                lane_sum = lane_sum + {{(WIDE-PROD_BITS){prod[PROD_BITS-1]}}, prod};
            end
            acc_wide = {{(WIDE-ACC_BITS){acc[k][ACC_BITS-1]}}, acc[k]} + lane_sum;
            acc_next[k] = acc_wide[ACC_BITS-1:0];
            if (acc_wide > ACC_MAX) begin
                acc_next[k]  = ACC_MAX[ACC_BITS-1:0];
                clamp_hit[k] = 1'b1;
            end else if (acc_wide < ACC_MIN) begin
                acc_next[k]  = ACC_MIN[ACC_BITS-1:0];
                clamp_hit[k] = 1'b1;
            end
        end
    end

    // Strict '>' keeps the earlier index on ties; class 0 seeds best and resets second.
    always_comb begin
        cand       = acc[cls_idx];
        best_n     = best_q;
        second_n   = second_q;
        best_idx_n = best_idx_q;
        if (cls_idx == '0) begin
            best_n     = cand;
            second_n   = SCORE_MIN;
            best_idx_n = '0;
        end else if (cand > best_q) begin
            second_n   = best_q;
            best_n     = cand;
            best_idx_n = cls_idx;
        end else if (cand > second_q) begin
            second_n   = cand;
        end
        diff = {best_n[ACC_BITS-1], best_n} - {second_n[ACC_BITS-1], second_n};
        for (int k = 0; k < NUM_CLASSES; k++) scores_pack[k*ACC_BITS +: ACC_BITS] = acc[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt        <= '0;
            cls_idx         <= '0;
            pipe_valid      <= 1'b0;
            ovf_run         <= 1'b0;
            feat_q          <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) acc[k] <= '0;
            best_q          <= '0;
            second_q        <= '0;
            best_idx_q      <= '0;
            bus.scores_flat <= '0;
            bus.best_class  <= '0;
            bus.margin      <= '0;
            bus.overflow    <= 1'b0;
        end else if (bus.abort) begin
            pipe_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    for (int k = 0; k < NUM_CLASSES; k++) acc[k] <= bus.bias_flat[k*ACC_BITS +: ACC_BITS];
                    beat_cnt   <= '0;
                    ovf_run    <= 1'b0;
                    pipe_valid <= 1'b0;
                end
                RUN, DRAIN: begin
                    if (pipe_valid) begin
                        for (int k = 0; k < NUM_CLASSES; k++) acc[k] <= acc_next[k];
                        ovf_run <= ovf_run | (|clamp_hit);
                    end
                    if (handshake) begin
                        feat_q   <= bus.feat_data;
                        beat_cnt <= beat_cnt + ADDR_BITS'(1);
                    end
                    pipe_valid <= handshake;
                    cls_idx    <= '0;
                end
                ARGMAX: begin
                    best_q     <= best_n;
                    second_q   <= second_n;
                    best_idx_q <= best_idx_n;
                    cls_idx    <= cls_idx + CLASS_BITS'(1);
                    if (cls_idx == CLASS_BITS'(NUM_CLASSES - 1)) begin
                        bus.scores_flat <= scores_pack;
                        bus.best_class  <= best_idx_n;
                        bus.margin      <= diff[ACC_BITS] ? '1 : diff[ACC_BITS-1:0];
                        bus.overflow    <= ovf_run;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
